// File: rtl/inst_fetch_stage.sv
// Instruction fetch stage: registered PC drives the instruction pads, returned words
// land in a 2-entry skid FIFO that presents {pc, inst} to decode with a valid/stall handshake.
module inst_fetch_stage #(
    parameter int                ADDR_W   = 4,
    parameter int                INST_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic [INST_W-1:0] inst_data,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              if_valid,
    output logic [INST_W-1:0] if_inst,
    output logic [ADDR_W-1:0] if_pc
);

    logic [ADDR_W-1:0] pc_r;
    logic              req_r;
    logic [ADDR_W-1:0] req_pc_r;
    logic [1:0]        count_r;
    logic              if_valid_r;
    logic [ADDR_W-1:0] head_pc_r;
    logic [INST_W-1:0] head_inst_r;
    logic [ADDR_W-1:0] tail_pc_r;
    logic [INST_W-1:0] tail_inst_r;

    logic              pop_s;
    logic              push_s;
    logic              issue_s;
    logic [2:0]        occ_s;
    logic [1:0]        wr_idx_s;
    logic [1:0]        count_nxt_s;

    // Handshake decode: pop, push, issue throttle and next FIFO occupancy.
    always_comb begin
        pop_s    = if_valid_r & ~stall;
        push_s   = req_r & ~redirect_valid;
        // Occupancy after this edge if the in-flight word lands; issue only while it stays below 2.
        occ_s    = {1'b0, count_r} - {2'b00, pop_s} + {2'b00, req_r};
        issue_s  = ~redirect_valid & (occ_s < 3'd2);
        wr_idx_s = count_r - {1'b0, pop_s};
        if (redirect_valid) begin
            count_nxt_s = 2'd0;
        end else begin
            count_nxt_s = count_r - {1'b0, pop_s} + {1'b0, push_s};
        end
    end

    // PC and in-flight request tracking; a redirect overrides everything else.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r     <= RESET_PC;
            req_r    <= 1'b0;
            req_pc_r <= {ADDR_W{1'b0}};
        end else if (redirect_valid) begin
            pc_r     <= redirect_target;
            req_r    <= 1'b0;
            req_pc_r <= req_pc_r;
        end else if (issue_s) begin
            pc_r     <= pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            req_r    <= 1'b1;
            req_pc_r <= pc_r;
        end else begin
            pc_r     <= pc_r;
            req_r    <= 1'b0;
            req_pc_r <= req_pc_r;
        end
    end

    // Skid FIFO storage: head is always entry 0, tail shifts forward on a pop from full.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r     <= 2'd0;
            if_valid_r  <= 1'b0;
            head_pc_r   <= {ADDR_W{1'b0}};
            head_inst_r <= {INST_W{1'b0}};
            tail_pc_r   <= {ADDR_W{1'b0}};
            tail_inst_r <= {INST_W{1'b0}};
        end else begin
            count_r    <= count_nxt_s;
            if_valid_r <= (count_nxt_s != 2'd0);
            if (pop_s && (count_r == 2'd2)) begin
                head_pc_r   <= tail_pc_r;
                head_inst_r <= tail_inst_r;
            end
            if (push_s) begin
                if (wr_idx_s == 2'd0) begin
                    head_pc_r   <= req_pc_r;
                    head_inst_r <= inst_data;
                end else begin
                    tail_pc_r   <= req_pc_r;
                    tail_inst_r <= inst_data;
                end
            end
        end
    end

    assign inst_addr = pc_r;
    assign if_valid  = if_valid_r;
    assign if_inst   = head_inst_r;
    assign if_pc     = head_pc_r;

    a_count_range: assert property (@(posedge clk) disable iff (!rst) count_r <= 2'd2);
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
                                    !(push_s && (count_r == 2'd2) && !pop_s));

endmodule
